mem_stage_mc: RTL and testbench

- Multi-cycle, parametrised memory stage for the pipelined processor; successor to the single-cycle memory stage.
- Holds a word-addressed behavioural data memory behind a fixed-latency access model.
- Raises a stall to the pipeline while an access is in flight, and pulses done when the access completes.
- Reports illegal requests through a registered error flag.

---
 rtl/mem_pkg.sv | 24 ++
 rtl/mem_stage_mc_if.sv | 27 ++
 rtl/mem_array_sp.sv | 51 +++++
 rtl/mem_stage_mc.sv | 116 +++++++++++
 tb/tb_mem_stage_mc.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared types and sizing helpers for the multi-cycle memory stage.
package mem_pkg;

    localparam int MEM_DATA_W = 16;
    localparam int MEM_ADDR_W = 16;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Ceiling log2; returns 0 for n <= 1.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mem_stage_mc_if.sv
// Pipeline-to-memory-stage bus: request side driven by the pipeline (master).
interface mem_stage_mc_if #(
    parameter int DATA_W = mem_pkg::MEM_DATA_W,
    parameter int ADDR_W = mem_pkg::MEM_ADDR_W
) ();

    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              mem_read;
    logic              mem_write;
    logic              createdump;
    logic [DATA_W-1:0] rdata;
    logic              stall;
    logic              done;
    logic              err;

    modport master (
        output addr, wdata, mem_read, mem_write, createdump,
        input  rdata, stall, done, err
    );

    modport slave (
        input  addr, wdata, mem_read, mem_write, createdump,
        output rdata, stall, done, err
    );

endinterface

// File: rtl/mem_array_sp.sv
// Single-port word array with registered read, full clear on reset and a simulation dump hook.
module mem_array_sp
    import mem_pkg::*;
#(
    parameter int DATA_W = MEM_DATA_W,
    parameter int DEPTH  = 256,
    parameter int IDX_W  = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              we,
    input  logic [IDX_W-1:0]  idx,
    input  logic [DATA_W-1:0] wdata,
    input  logic              dump,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_reg [DEPTH];
    logic [DATA_W-1:0] rdata_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
            rdata_reg <= '0;
        end else begin
            if (we) begin
                mem_reg[idx] <= wdata;
            end
            // Read-before-write: a same-edge read returns the old word.
            rdata_reg <= mem_reg[idx];
        end
    end

    assign rdata = rdata_reg;

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!srst && dump) begin
            for (int i = 0; i < DEPTH; i++) begin
                $display("mem_dump[%0d] = %h", i, mem_reg[i]);
            end
        end
    end
`else
    logic unused_dump;
    assign unused_dump = dump;
`endif

endmodule

// File: rtl/mem_stage_mc.sv
// Multi-cycle memory stage: fixed-latency access FSM, pipeline stall and error flag.
// Optional MEM_ALIGN_CHECK_EN flags odd byte addresses as errors.
module mem_stage_mc
    import mem_pkg::*;
#(
    parameter int DATA_W  = MEM_DATA_W,
    parameter int ADDR_W  = MEM_ADDR_W,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input logic          clk,
    input logic          rst,
    mem_stage_mc_if.slave bus
);

    localparam int IDX_W = clog2(DEPTH);
    localparam int CNT_W = (LATENCY > 1) ? clog2(LATENCY) : 1;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [IDX_W-1:0]   idx_reg;
    logic [DATA_W-1:0]  wdata_reg;
    logic               rd_reg, wr_reg, bad_reg;
    logic               done_reg, err_reg;
    logic [DATA_W-1:0]  rdata_hold_reg;
    logic [DATA_W-1:0]  rdata_out;
    logic [DATA_W-1:0]  arr_rdata;
    logic               req, accept, finish, bad_req, arr_we, dump;
    logic               unused_addr;

    assign req    = bus.mem_read | bus.mem_write;
    assign accept = (state_reg == IDLE) & req;
    assign finish = (state_reg == BUSY) & (cnt_reg == '0);

`ifdef MEM_ALIGN_CHECK_EN
    assign bad_req = (bus.mem_read & bus.mem_write) | bus.addr[0];
`else
    assign bad_req = bus.mem_read & bus.mem_write;
`endif
    assign unused_addr = ^bus.addr;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (req) begin
                    state_next = BUSY;
                    cnt_next   = CNT_W'(LATENCY - 1);
                end
            end
            BUSY: begin
                if (cnt_reg == '0) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            idx_reg        <= '0;
            wdata_reg      <= '0;
            rd_reg         <= 1'b0;
            wr_reg         <= 1'b0;
            bad_reg        <= 1'b0;
            done_reg       <= 1'b0;
            err_reg        <= 1'b0;
            rdata_hold_reg <= '0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            done_reg       <= finish;
            err_reg        <= finish & bad_reg;
            rdata_hold_reg <= rdata_out;
            if (accept) begin
                idx_reg   <= bus.addr[IDX_W:1];
                wdata_reg <= bus.wdata;
                rd_reg    <= bus.mem_read;
                wr_reg    <= bus.mem_write;
                bad_reg   <= bad_req;
            end
        end
    end

    // The array samples the word on the completing edge; it is exposed in
    // the done cycle of a good read and held from then on.
    assign rdata_out = (done_reg & rd_reg & ~err_reg) ? arr_rdata : rdata_hold_reg;
    assign arr_we    = finish & wr_reg & ~bad_reg;
    assign dump      = bus.createdump & (state_reg == IDLE) & ~req;

    mem_array_sp #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk   (clk),
        .srst  (rst),
        .we    (arr_we),
        .idx   (idx_reg),
        .wdata (wdata_reg),
        .dump  (dump),
        .rdata (arr_rdata)
    );

    assign bus.rdata = rdata_out;
    assign bus.stall = accept | (state_reg == BUSY);
    assign bus.done  = done_reg;
    assign bus.err   = err_reg;

endmodule

// File: tb/tb_mem_stage_mc.sv
// Scoreboard bench for mem_stage_mc: stimulus pushes expectations, a monitor checks each done.
module tb_mem_stage_mc;

    localparam int LAT = 2;

    typedef struct {
        logic [15:0] rdata;
        logic        err;
        string       nm;
    } exp_t;

    logic clk;
    logic rst;
    exp_t sb[$];
    exp_t mon_e;
    int   checks;
    int   errors;

    mem_stage_mc_if #(.DATA_W(16), .ADDR_W(16)) bus ();

    mem_stage_mc #(
        .DATA_W  (16),
        .ADDR_W  (16),
        .DEPTH   (256),
        .LATENCY (LAT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    // Monitor: every done must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.done) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1 expected no pending access");
                end else begin
                    mon_e = sb.pop_front();
                    check({mon_e.nm, "_rdata"}, 32'(bus.rdata), 32'(mon_e.rdata));
                    check({mon_e.nm, "_err"}, 32'(bus.err), 32'(mon_e.err));
                    $display("txn %s: rdata=%h err=%b (want %h/%b)",
                             mon_e.nm, bus.rdata, bus.err, mon_e.rdata, mon_e.err);
                end
            end else if (bus.err) begin
                checks++;
                errors++;
                $display("FAIL err_without_done: got err=1 expected 0");
            end
        end
    end

    // Called just after a rising edge with the DUT idle; returns just after a rising edge.
    task automatic access(input logic [15:0] a, input logic [15:0] d, input logic r, input logic w,
                          input logic [15:0] er, input logic ee, input string nm);
        int   lat;
        int   st;
        logic st_done;
        lat     = -1;
        st      = 0;
        st_done = 1'b1;
        bus.addr      = a;
        bus.wdata     = d;
        bus.mem_read  = r;
        bus.mem_write = w;
        sb.push_back('{er, ee, nm});
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (bus.done) begin
                lat     = i;
                st_done = bus.stall;
                break;
            end
            if (bus.stall) st++;
            @(posedge clk);
            #1;
            if (i == 0) begin
                bus.mem_read  = 1'b0;
                bus.mem_write = 1'b0;
            end
        end
        check({nm, "_latency"}, 32'(lat), 32'(LAT + 1));
        check({nm, "_stall_cycles"}, 32'(st), 32'(LAT + 1));
        check({nm, "_stall_in_done"}, 32'(st_done), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [6:0] sv;
        logic [6:0] dv;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.addr = '0;
        bus.wdata = '0;
        bus.mem_read = 1'b0;
        bus.mem_write = 1'b0;
        bus.createdump = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        check("rst_stall", 32'(bus.stall), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_rdata", 32'(bus.rdata), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        @(posedge clk);
        #1;

        access(16'h0010, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, "rd_0010_init");
        access(16'h0004, 16'hBEEF, 1'b0, 1'b1, 16'h0000, 1'b0, "wr_0004");
        access(16'h0004, 16'h0000, 1'b1, 1'b0, 16'hBEEF, 1'b0, "rd_0004");

        // Back-to-back: write then a read held through the write's done cycle.
        bus.addr = 16'h0010; bus.wdata = 16'h5555; bus.mem_read = 1'b0; bus.mem_write = 1'b1;
        sb.push_back('{16'hBEEF, 1'b0, "b2b_wr"});
        sb.push_back('{16'h5555, 1'b0, "b2b_rd"});
        sv = '0;
        dv = '0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            sv[i] = bus.stall;
            dv[i] = bus.done;
            @(posedge clk);
            #1;
            if (i == 0) begin bus.mem_read = 1'b1; bus.mem_write = 1'b0; end
            if (i == 3) bus.mem_read = 1'b0;
        end
        check("b2b_stall_pattern", 32'(sv), 32'h3F);
        check("b2b_done_pattern", 32'(dv), 32'h48);

        access(16'h0202, 16'h1234, 1'b0, 1'b1, 16'h5555, 1'b0, "wr_0202");
        access(16'h0002, 16'h0000, 1'b1, 1'b0, 16'h1234, 1'b0, "rd_0002_wrap");
        access(16'h0008, 16'hA5A5, 1'b0, 1'b1, 16'h1234, 1'b0, "wr_0008");
        access(16'h0008, 16'hFFFF, 1'b1, 1'b1, 16'h1234, 1'b1, "conflict_0008");
        access(16'h0008, 16'h0000, 1'b1, 1'b0, 16'hA5A5, 1'b0, "rd_0008_after_conflict");

        // Reset in the second BUSY cycle of a write: no done, array cleared.
        bus.addr = 16'h000C; bus.wdata = 16'h7777; bus.mem_read = 1'b0; bus.mem_write = 1'b1;
        @(posedge clk);
        #1;
        bus.mem_write = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("abort_no_done", 32'(bus.done), 32'd0);
            @(posedge clk);
            #1;
        end
        access(16'h000C, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, "rd_000c_after_abort");
        access(16'h0008, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, "rd_0008_cleared");

`ifdef MEM_ALIGN_CHECK_EN
        access(16'h0003, 16'h9999, 1'b0, 1'b1, 16'h0000, 1'b1, "wr_0003_misaligned");
        access(16'h0002, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, "rd_0002_unchanged");
`else
        access(16'h0003, 16'h9999, 1'b0, 1'b1, 16'h0000, 1'b0, "wr_0003_odd");
        access(16'h0002, 16'h0000, 1'b1, 1'b0, 16'h9999, 1'b0, "rd_0002_odd_alias");
`endif

        repeat (4) @(posedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
